// File: rtl/proximo_pc_if.sv
// Control-flow bus between decode, the next-address stage and the program counter.
// valido qualifies op/imediato/cond for exactly one cycle; there is no ready: the stage accepts every valid op.
interface proximo_pc_if;
  logic [7:0] atualSinal;
  logic       valido;
  logic [2:0] op;
  logic [7:0] imediato;
  logic       cond;
  logic [7:0] proxSinal;
  logic       pilha_vazia;
  logic       pilha_cheia;
  logic [3:0] profundidade;
  logic       erro;

  modport master (
    output atualSinal, valido, op, imediato, cond,
    input  proxSinal, pilha_vazia, pilha_cheia, profundidade, erro
  );

  modport slave (
    input  atualSinal, valido, op, imediato, cond,
    output proxSinal, pilha_vazia, pilha_cheia, profundidade, erro
  );
endinterface

// File: rtl/proximo_pc.sv
// Next-address stage for the nRisk-8bits fetch path: increment, branches, jumps and
// call/return through a small return-address stack with a sticky fault flag.
module proximo_pc #(
  parameter int PROFUNDIDADE = 4
) (
  input logic        clock,
  input logic        reset,
  proximo_pc_if.slave bus
);

  localparam int IW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

  typedef enum logic [2:0] {
    OP_SEQ         = 3'b000,
    OP_DESVIO      = 3'b001,
    OP_SALTO       = 3'b010,
    OP_CHAMADA     = 3'b011,
    OP_RETORNO     = 3'b100,
    OP_DESVIO_COND = 3'b101
  } op_t;

  logic [7:0]    pilha [PROFUNDIDADE];
  logic [3:0]    cnt;
  logic          erro_q;
  logic          vazia;
  logic          cheia;
  logic [IW-1:0] top_idx;
  logic [7:0]    topo;
  logic [7:0]    inc;
  logic [7:0]    rel;
  logic [7:0]    prox;
  logic          push;
  logic          pop;
  logic          fault;

  assign vazia   = (cnt == 4'd0);
  assign cheia   = (cnt == 4'(PROFUNDIDADE));
  assign top_idx = IW'(cnt - 4'd1);
  assign topo    = pilha[top_idx];

  always_comb begin
    inc   = bus.atualSinal + 8'd1;
    // Sign extension to 8 bits is the identity, so a plain modulo-256 add is the relative branch.
    rel   = bus.atualSinal + bus.imediato;
    prox  = bus.atualSinal;
    push  = 1'b0;
    pop   = 1'b0;
    fault = 1'b0;
    if (reset) begin
      prox = 8'h00;
    end else if (bus.valido) begin
      case (op_t'(bus.op))
        OP_DESVIO:      prox = rel;
        OP_SALTO:       prox = bus.imediato;
        OP_DESVIO_COND: prox = bus.cond ? rel : inc;
        OP_CHAMADA: begin
          if (cheia) begin
            prox  = inc;
            fault = 1'b1;
          end else begin
            prox = bus.imediato;
            push = 1'b1;
          end
        end
        OP_RETORNO: begin
          if (vazia) begin
            prox  = inc;
            fault = 1'b1;
          end else begin
            prox = topo;
            pop  = 1'b1;
          end
        end
        default:        prox = inc;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= 4'd0;
      erro_q <= 1'b0;
      for (int i = 0; i < PROFUNDIDADE; i++) pilha[i] <= 8'h00;
    end else begin
      if (push) begin
        pilha[cnt[IW-1:0]] <= inc;
        cnt                <= cnt + 4'd1;
      end else if (pop) begin
        cnt <= cnt - 4'd1;
      end
      if (fault) erro_q <= 1'b1;
    end
  end

  assign bus.proxSinal    = prox;
  assign bus.pilha_vazia  = vazia;
  assign bus.pilha_cheia  = cheia;
  assign bus.profundidade = cnt;
  assign bus.erro         = erro_q;

endmodule

// File: tb/tb_proximo_pc.sv
// Bench for proximo_pc: vector table plus reset and random sequences, checked through
// expected-value queues filled when each operation is driven.
module tb_proximo_pc;
  localparam int PROF = 4;
  localparam logic [2:0] SEQ = 3'b000, DES = 3'b001, SAL = 3'b010,
                         CHA = 3'b011, RET = 3'b100, DCO = 3'b101;

  typedef struct {
    logic [7:0] atual;
    logic       v;
    logic [2:0] op;
    logic [7:0] imm;
    logic       c;
    logic [7:0] exp_prox;
    logic [3:0] exp_depth;
    logic       exp_erro;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] exp_q[$];
  logic [6:0] flag_q[$];
  vec_t tbl[$];

  always #5 clock = ~clock;

  proximo_pc_if bus();

  proximo_pc #(.PROFUNDIDADE(PROF)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  function automatic vec_t mk(input logic [7:0] a, input logic v, input logic [2:0] op,
                              input logic [7:0] imm, input logic c, input logic [7:0] ep,
                              input logic [3:0] ed, input logic ee);
    vec_t r;
    r.atual = a; r.v = v; r.op = op; r.imm = imm; r.c = c;
    r.exp_prox = ep; r.exp_depth = ed; r.exp_erro = ee;
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic v, input logic [2:0] op,
                       input logic [7:0] imm, input logic c);
    bus.atualSinal = a;
    bus.valido     = v;
    bus.op         = op;
    bus.imediato   = imm;
    bus.cond       = c;
  endtask

  task automatic check_prox();
    if (exp_q.size() == 0) begin
      check("prox_queue_empty", 8'h01, 8'h00);
    end else begin
      check("proxSinal", bus.proxSinal, exp_q.pop_front());
    end
  endtask

  task automatic check_flags();
    logic [6:0] ef;
    if (flag_q.size() == 0) begin
      check("flag_queue_empty", 8'h01, 8'h00);
    end else begin
      ef = flag_q.pop_front();
      check("profundidade", {4'h0, bus.profundidade}, {4'h0, ef[3:0]});
      check("pilha_vazia", {7'h0, bus.pilha_vazia}, {7'h0, ef[4]});
      check("pilha_cheia", {7'h0, bus.pilha_cheia}, {7'h0, ef[5]});
      check("erro", {7'h0, bus.erro}, {7'h0, ef[6]});
    end
  endtask

  task automatic push_flags(input logic [3:0] d, input logic e);
    flag_q.push_back({e, (d == 4'(PROF)), (d == 4'd0), d});
  endtask

  task automatic step(input vec_t v);
    @(negedge clock);
    drive(v.atual, v.v, v.op, v.imm, v.c);
    exp_q.push_back(v.exp_prox);
    push_flags(v.exp_depth, v.exp_erro);
    #1;
    check_prox();
    @(posedge clock);
    #1;
    check_flags();
  endtask

  // Holds reset for n cycles while presenting a valid op; proxSinal must read 0 throughout.
  task automatic reset_cycles(input int n, input logic [2:0] op);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset = 1'b1;
      drive(8'h33, 1'b1, op, 8'h77, 1'b1);
      exp_q.push_back(8'h00);
      #1;
      check_prox();
    end
    @(negedge clock);
    reset = 1'b0;
    drive(8'h00, 1'b0, SEQ, 8'h00, 1'b0);
    push_flags(4'd0, 1'b0);
    #1;
    check_flags();
  endtask

  initial begin
    logic [7:0] a, imm, ep;
    logic [2:0] op;
    logic       c;

    drive(8'h00, 1'b0, SEQ, 8'h00, 1'b0);
    reset_cycles(2, CHA);

    // Basic arithmetic, branches, reserved ops.
    tbl.push_back(mk(8'h05, 1, SEQ, 8'h00, 0, 8'h06, 0, 0));
    tbl.push_back(mk(8'hFF, 1, SEQ, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(8'h10, 1, DES, 8'hFE, 0, 8'h0E, 0, 0));
    tbl.push_back(mk(8'h10, 1, DCO, 8'h04, 1, 8'h14, 0, 0));
    tbl.push_back(mk(8'h10, 1, DCO, 8'h04, 0, 8'h11, 0, 0));
    tbl.push_back(mk(8'h10, 1, SAL, 8'h80, 0, 8'h80, 0, 0));
    tbl.push_back(mk(8'h02, 1, DES, 8'hFC, 0, 8'hFE, 0, 0));
    tbl.push_back(mk(8'h10, 1, 3'b110, 8'h33, 1, 8'h11, 0, 0));
    tbl.push_back(mk(8'h10, 1, 3'b111, 8'h33, 1, 8'h11, 0, 0));
    // Nested call/return.
    tbl.push_back(mk(8'h20, 1, CHA, 8'h40, 0, 8'h40, 1, 0));
    tbl.push_back(mk(8'h45, 1, CHA, 8'h60, 0, 8'h60, 2, 0));
    tbl.push_back(mk(8'h70, 1, RET, 8'h00, 0, 8'h46, 1, 0));
    tbl.push_back(mk(8'h70, 1, RET, 8'h00, 0, 8'h21, 0, 0));
    // Fill the stack, then overflow.
    tbl.push_back(mk(8'h01, 1, CHA, 8'hA0, 0, 8'hA0, 1, 0));
    tbl.push_back(mk(8'h02, 1, CHA, 8'hA0, 0, 8'hA0, 2, 0));
    tbl.push_back(mk(8'h03, 1, CHA, 8'hA0, 0, 8'hA0, 3, 0));
    tbl.push_back(mk(8'h04, 1, CHA, 8'hA0, 0, 8'hA0, 4, 0));
    tbl.push_back(mk(8'h30, 1, CHA, 8'h90, 0, 8'h31, 4, 1));
    tbl.push_back(mk(8'h99, 1, RET, 8'h00, 0, 8'h05, 3, 1));
    tbl.push_back(mk(8'h99, 1, RET, 8'h00, 0, 8'h04, 2, 1));
    tbl.push_back(mk(8'h99, 1, RET, 8'h00, 0, 8'h03, 1, 1));
    tbl.push_back(mk(8'h99, 1, RET, 8'h00, 0, 8'h02, 0, 1));
    // Underflow and hold.
    tbl.push_back(mk(8'h50, 1, RET, 8'h00, 0, 8'h51, 0, 1));
    tbl.push_back(mk(8'h77, 0, CHA, 8'h12, 0, 8'h77, 0, 1));
    tbl.push_back(mk(8'h10, 1, CHA, 8'h30, 0, 8'h30, 1, 1));
    tbl.push_back(mk(8'h30, 0, RET, 8'h00, 0, 8'h30, 1, 1));
    tbl.push_back(mk(8'h30, 1, RET, 8'h00, 0, 8'h11, 0, 1));
    // Return address wraps when calling from 0xFF.
    tbl.push_back(mk(8'hFF, 1, CHA, 8'h55, 0, 8'h55, 1, 1));
    tbl.push_back(mk(8'h08, 1, RET, 8'h00, 0, 8'h00, 0, 1));

    foreach (tbl[i]) step(tbl[i]);

    // Reset mid-sequence discards pending returns and clears erro.
    step(mk(8'h20, 1, CHA, 8'h40, 0, 8'h40, 1, 1));
    step(mk(8'h45, 1, CHA, 8'h60, 0, 8'h60, 2, 1));
    reset_cycles(1, RET);
    step(mk(8'h50, 1, RET, 8'h00, 0, 8'h51, 0, 1));

    // Random sequential/branch/jump traffic against a small reference model.
    for (int i = 0; i < 24; i++) begin
      a   = 8'($urandom_range(0, 255));
      imm = 8'($urandom_range(0, 255));
      c   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin op = SEQ; ep = a + 8'd1; end
        1: begin op = DES; ep = a + imm; end
        2: begin op = SAL; ep = imm; end
        default: begin op = DCO; ep = c ? (a + imm) : (a + 8'd1); end
      endcase
      step(mk(a, 1, op, imm, c, ep, 0, 1));
    end

    if (exp_q.size() != 0 || flag_q.size() != 0)
      check("scoreboard_drain", 8'(exp_q.size() + flag_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/proximo_pc.md
# proximo_pc

Next-address stage of the nRisk-8bits fetch path: computes the 8-bit address the program counter loads on its next cycle. Supports sequential increment, relative and conditional branches, absolute jumps, and call/return through an internal return-address stack (LIFO). Sits directly upstream of the program counter:

- takes the counter's current address and the decoded control-flow operation;
- drives the counter's next-address input.

## Interface

Parameters:
- PROFUNDIDADE, 4, number of return-address stack entries (legal 2..8)

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- atualSinal  input  8  current program counter value
- valido  input  1  operation on op/imediato/cond is valid this cycle
- op  input  3  control-flow operation (encoding below)
- imediato  input  8  branch offset (two's complement) or absolute target
- cond  input  1  branch condition for conditional branch
- proxSinal  output  8  next address, to program counter
- pilha_vazia  output  1  stack holds no entries
- pilha_cheia  output  1  stack holds PROFUNDIDADE entries
- profundidade  output  4  current entry count
- erro  output  1  sticky fault flag (overflow/underflow)

## Operation

- op encoding:
  - 000 SEQ: proxSinal = atualSinal + 1
  - 001 DESVIO: proxSinal = atualSinal + sign-extended imediato
  - 010 SALTO: proxSinal = imediato
  - 011 CHAMADA: push atualSinal + 1; proxSinal = imediato
  - 100 RETORNO: pop; proxSinal = popped (top) entry
  - 101 DESVIO_COND: DESVIO if cond=1, else SEQ
  - 110, 111: reserved, behave as SEQ, no error
- All address arithmetic is modulo 256, with silent wrap:
  - 0xFF + 1 = 0x00
  - 0x02 + 0xFC = 0xFE
- valido=0: proxSinal = atualSinal (hold); no stack change regardless of op.
- Stack: PROFUNDIDADE x 8-bit registers plus pointer; top = most recently pushed entry.
- CHAMADA while pilha_cheia=1:
  - no push;
  - proxSinal = atualSinal + 1 (call suppressed);
  - erro set.
- RETORNO while pilha_vazia=1:
  - no pop;
  - proxSinal = atualSinal + 1;
  - erro set.
- erro is sticky: once set, it stays set until reset.
- Stack contents not addressed by the pointer are don't-care. Verification must not check them.
- pilha_vazia = (profundidade == 0); pilha_cheia = (profundidade == PROFUNDIDADE).

## Timing

- proxSinal is combinational from the following, with zero-cycle latency so the program counter captures it in the same cycle:
  - atualSinal, valido, op, imediato, cond;
  - registered stack top and flags.
- Stack push/pop, profundidade and erro update on the rising clock edge at the end of the cycle in which the op is presented.
- The flags reflect the new state from the following cycle.
- One operation per cycle. Back-to-back CHAMADA/RETORNO are legal: a RETORNO in the cycle after a CHAMADA returns the address just pushed.
- reset=1 at a rising edge forces:
  - profundidade = 0, pilha_vazia = 1, pilha_cheia = 0, erro = 0;
  - all stack entries = 0x00.
- While reset is high:
  - proxSinal = 0x00;
  - no stack operation takes effect, regardless of valido/op.
- Reset mid-sequence discards every pending return address. The first RETORNO afterwards underflows.
- Before the first reset, state is undefined. The bench must apply reset for at least one cycle.

## Test plan

- Reset then SEQ: reset high 2 cycles; with atualSinal=0x05, op=000, valido=1 -> proxSinal=0x06. Flags after reset: pilha_vazia=1, erro=0. With atualSinal=0xFF -> proxSinal=0x00.
- Branches, atualSinal=0x10:
  - DESVIO imediato=0xFE -> proxSinal=0x0E;
  - DESVIO_COND imediato=0x04, cond=1 -> 0x14; cond=0 -> 0x11;
  - SALTO imediato=0x80 -> 0x80.
- Nested call/return:
  - CHAMADA at 0x20 (target 0x40), then CHAMADA at 0x45 (target 0x60);
  - then RETORNO twice -> proxSinal 0x46, then 0x21;
  - profundidade sequence 1, 2, 1, 0; erro=0 throughout.
- Overflow with PROFUNDIDADE=4:
  - four CHAMADAs -> pilha_cheia=1;
  - fifth CHAMADA at 0x30, imediato=0x90 -> proxSinal=0x31, profundidade stays 4, erro=1;
  - subsequent RETORNO still returns the 4th pushed address.
- Underflow and hold:
  - RETORNO with stack empty at 0x50 -> proxSinal=0x51, erro=1 and stays 1;
  - valido=0 with op=011 -> proxSinal=atualSinal, profundidade unchanged.
- Reset mid-operation:
  - push two entries, assert reset one cycle -> profundidade=0, erro=0;
  - next RETORNO underflows (erro=1).
